// File: rtl/shift_reg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : shift_reg_pkg
//  Description : Definitions shared by the serial register link transmitter
//                and receiver: the two-state FSM encoding and a constant
//                ceiling-log2 helper used to size the bit counters.
//  Ports       : none (package)
//  Revision    : 1.0  initial release
// ============================================================================
package shift_reg_pkg;

   // FSM state encoding, kept as plain one-bit constants so older code that
   // compares against literal values keeps working.
   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_SHIFT = 1'b1;

   // Ceiling log2 for sizing counters at elaboration time.
   // clog2(1)=0, clog2(2)=1, clog2(4)=2, clog2(5)=3.
   function automatic int clog2(input int value);
      int result;
      int remaining;
      result = 0;
      for (remaining = value - 1; remaining > 0; remaining = remaining >> 1) begin
         result = result + 1;
      end
      return result;
   endfunction

endpackage : shift_reg_pkg
`default_nettype wire

// File: rtl/shift_register_piso_tx.sv
`default_nettype none
// ============================================================================
//  Module      : shift_register_piso_tx
//  Description : Parallel-in serial-out transmitter. Accepts a WIDTH-bit word
//                over a valid/ready load handshake and shifts it out one bit
//                per accepted serial beat. A new word may load on the same
//                edge that consumes the last bit of the current one, so words
//                stream back-to-back without an idle gap.
//  Parameters  : WIDTH     - word width in bits (>= 2)
//                LSB_FIRST - 0: MSB leaves first, 1: LSB leaves first
//  Ports       : clk          - clock, all state changes on posedge
//                clear_n      - synchronous active-low reset
//                load_valid   - parallel_in holds a word to send
//                parallel_in  - word to serialize
//                load_ready   - a word can be accepted this cycle
//                serial_out   - current serial bit
//                serial_valid - serial_out carries a data bit
//                serial_ready - downstream consumes serial_out this cycle
//                done         - one-cycle pulse after a word's last bit
//  Revision    : 1.0  initial release
// ============================================================================
module shift_register_piso_tx
   import shift_reg_pkg::*;
#(
   parameter int WIDTH     = 4,
   parameter bit LSB_FIRST = 1'b0
) (
   input  logic             clk,
   input  logic             clear_n,
   input  logic             load_valid,
   input  logic [WIDTH-1:0] parallel_in,
   output logic             load_ready,
   output logic             serial_out,
   output logic             serial_valid,
   input  logic             serial_ready,
   output logic             done
);

   localparam int                 c_CNT_W    = clog2(WIDTH);
   localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);
   localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

   logic [0:0]         r_state;
   logic [WIDTH-1:0]   r_shift;
   logic [c_CNT_W-1:0] r_count;
   logic               r_done;

   logic [WIDTH-1:0]   w_shift_next;
   logic               w_out_bit;
   logic               w_shifting;
   logic               w_beat;
   logic               w_last_beat;
   logic               w_load;

   // ------------------------------------------------------------------------
   // Output end of the shifter depends on bit order. The vacated end is
   // zero-filled so stale data never re-emerges.
   // ------------------------------------------------------------------------
   if (LSB_FIRST) begin : g_lsb_first
      assign w_shift_next = {1'b0, r_shift[WIDTH-1:1]};
      assign w_out_bit    = r_shift[0];
   end else begin : g_msb_first
      assign w_shift_next = {r_shift[WIDTH-2:0], 1'b0};
      assign w_out_bit    = r_shift[WIDTH-1];
   end

   // ------------------------------------------------------------------------
   // Handshake decode. The count holds the number of bits still to follow
   // the one currently presented, so count==0 marks the final bit.
   // ------------------------------------------------------------------------
   assign w_shifting  = (r_state == ST_SHIFT);
   assign w_beat      = w_shifting && serial_ready;
   assign w_last_beat = w_beat && (r_count == '0);

   // Ready is combinational on serial_ready so the next word can be taken
   // on the very edge that retires the current word's last bit.
   assign load_ready  = (r_state == ST_IDLE) || w_last_beat;
   assign w_load      = load_valid && load_ready;

   // ------------------------------------------------------------------------
   // State, shifter and counter
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!clear_n) begin
         r_state <= ST_IDLE;
         r_shift <= '0;
         r_count <= '0;
         r_done  <= 1'b0;
      end else begin
         // Pulses for exactly one cycle after each completed word; when a
         // second word loads back-to-back this lines up with its first bit.
         r_done <= w_last_beat;

         if (w_load) begin
            // Loading takes priority: this also covers the back-to-back case
            // where the previous word finishes on the same edge.
            r_shift <= parallel_in;
            r_count <= c_CNT_LAST;
            r_state <= ST_SHIFT;
         end else if (w_beat) begin
            if (r_count != '0) begin
               r_shift <= w_shift_next;
               r_count <= r_count - c_CNT_ONE;
            end else begin
               r_state <= ST_IDLE;
            end
         end
         // serial_ready low in SHIFT: everything holds.
      end
   end

   assign serial_out   = w_out_bit;
   assign serial_valid = w_shifting;
   assign done         = r_done;

endmodule : shift_register_piso_tx
`default_nettype wire

// File: tb/tb_shift_register_piso_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shift_register_piso_tx
//  Description : Self-checking bench. Two transmitters (MSB-first and
//                LSB-first) share one stimulus stream. A word-level model
//                tracks how many bits of the current word remain; accepted
//                words are expanded into expected bit queues and a separate
//                monitor checks every presented serial bit against them.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_shift_register_piso_tx;

   localparam int WIDTH = 4;

   logic             clk = 1'b0;
   logic             clear_n;
   logic             load_valid;
   logic [WIDTH-1:0] parallel_in;
   logic             serial_ready;

   logic lr_m, so_m, sv_m, dn_m;
   logic lr_l, so_l, sv_l, dn_l;

   int checks   = 0;
   int failures = 0;

   // Reference model state
   bit exp_m[$];
   bit exp_l[$];
   int rem      = 0;     // bits of the current word not yet consumed
   bit m_done   = 1'b0;
   bit out_zero = 1'b1;  // shifter known cleared by reset, nothing loaded since
   bit flush    = 1'b0;

   always #5 clk = ~clk;

   shift_register_piso_tx #(.WIDTH(WIDTH), .LSB_FIRST(1'b0)) dut_msb (
      .clk          (clk),
      .clear_n      (clear_n),
      .load_valid   (load_valid),
      .parallel_in  (parallel_in),
      .load_ready   (lr_m),
      .serial_out   (so_m),
      .serial_valid (sv_m),
      .serial_ready (serial_ready),
      .done         (dn_m)
   );

   shift_register_piso_tx #(.WIDTH(WIDTH), .LSB_FIRST(1'b1)) dut_lsb (
      .clk          (clk),
      .clear_n      (clear_n),
      .load_valid   (load_valid),
      .parallel_in  (parallel_in),
      .load_ready   (lr_l),
      .serial_out   (so_l),
      .serial_valid (sv_l),
      .serial_ready (serial_ready),
      .done         (dn_l)
   );

   task automatic chk(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   // One clock cycle: drive inputs just after a negedge, check the
   // cycle-level outputs against the model, advance the model across the
   // coming posedge, then wait for the next negedge.
   task automatic step(input logic clr, input logic lv, input logic [WIDTH-1:0] pin,
                       input logic sr, output bit acc);
      bit m_ready;
      clear_n      = clr;
      load_valid   = lv;
      parallel_in  = pin;
      serial_ready = sr;
      #1;
      if (flush) begin
         exp_m.delete();
         exp_l.delete();
         flush = 1'b0;
      end
      m_ready = (rem == 0) || (rem == 1 && sr);
      chk("load_ready_msb",   lr_m, m_ready);
      chk("load_ready_lsb",   lr_l, m_ready);
      chk("serial_valid_msb", sv_m, rem > 0);
      chk("serial_valid_lsb", sv_l, rem > 0);
      chk("done_msb",         dn_m, m_done);
      chk("done_lsb",         dn_l, m_done);
      if (out_zero) begin
         chk("serial_out_idle_msb", so_m, 1'b0);
         chk("serial_out_idle_lsb", so_l, 1'b0);
      end
      acc = 1'b0;
      if (!clr) begin
         rem      = 0;
         m_done   = 1'b0;
         out_zero = 1'b1;
         flush    = 1'b1;
      end else begin
         m_done = (rem == 1) && sr;
         if (rem > 0 && sr) rem--;
         if (lv && m_ready) begin
            acc      = 1'b1;
            rem      = WIDTH;
            out_zero = 1'b0;
            for (int i = WIDTH - 1; i >= 0; i--) exp_m.push_back(pin[i]);
            for (int i = 0; i < WIDTH; i++)      exp_l.push_back(pin[i]);
         end
      end
      @(negedge clk);
   endtask

   // Monitor: every presented bit must match the head of its queue; the
   // head is retired only when downstream consumes it.
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (sv_m) begin
            if (exp_m.size() == 0) chk("bit_msb_extra", sv_m, 1'b0);
            else begin
               chk("bit_msb", so_m, exp_m[0]);
               if (serial_ready) void'(exp_m.pop_front());
            end
         end
         if (sv_l) begin
            if (exp_l.size() == 0) chk("bit_lsb_extra", sv_l, 1'b0);
            else begin
               chk("bit_lsb", so_l, exp_l[0]);
               if (serial_ready) void'(exp_l.pop_front());
            end
         end
      end
   end

   initial begin
      bit               acc;
      bit               pend;
      logic [WIDTH-1:0] pword;
      int               guard;

      clear_n      = 1'b0;
      load_valid   = 1'b0;
      parallel_in  = '0;
      serial_ready = 1'b0;
      @(negedge clk);

      // Reset held two cycles, then released
      step(1'b0, 1'b1, 4'b1111, 1'b1, acc);
      step(1'b0, 1'b0, 4'b0000, 1'b1, acc);
      step(1'b1, 1'b0, 4'b0000, 1'b1, acc);

      // Single word, no stalls
      step(1'b1, 1'b1, 4'b1101, 1'b1, acc);
      repeat (6) step(1'b1, 1'b0, 4'b0000, 1'b1, acc);

      // Stall on bit 2 with a stray load attempt during the stall
      step(1'b1, 1'b1, 4'b1011, 1'b1, acc);
      step(1'b1, 1'b0, 4'b0000, 1'b1, acc);
      step(1'b1, 1'b0, 4'b0000, 1'b0, acc);
      step(1'b1, 1'b1, 4'b0000, 1'b0, acc);
      step(1'b1, 1'b0, 4'b0000, 1'b0, acc);
      repeat (5) step(1'b1, 1'b0, 4'b0000, 1'b1, acc);

      // Back-to-back words: second word held valid until taken
      step(1'b1, 1'b1, 4'b1010, 1'b1, acc);
      guard = 0;
      do begin
         step(1'b1, 1'b1, 4'b0110, 1'b1, acc);
         guard++;
      end while (!acc && guard < 10);
      chk("b2b_second_word_taken", acc, 1'b1);
      repeat (6) step(1'b1, 1'b0, 4'b0000, 1'b1, acc);

      // Reset in the middle of a word
      step(1'b1, 1'b1, 4'b0101, 1'b1, acc);
      step(1'b1, 1'b0, 4'b0000, 1'b1, acc);
      step(1'b1, 1'b0, 4'b0000, 1'b1, acc);
      step(1'b0, 1'b0, 4'b0000, 1'b1, acc);
      repeat (3) step(1'b1, 1'b0, 4'b0000, 1'b1, acc);

      // Randomized traffic; a pending word is held stable until accepted
      pend  = 1'b0;
      pword = '0;
      repeat (400) begin
         if (!pend && $urandom_range(0, 2) != 0) begin
            pend  = 1'b1;
            pword = WIDTH'($urandom);
         end
         step(($urandom_range(0, 59) != 0),
              pend,
              pend ? pword : WIDTH'($urandom),
              ($urandom_range(0, 3) != 0),
              acc);
         if (acc) pend = 1'b0;
      end

      // Drain and confirm every expected bit was delivered
      repeat (2 * WIDTH + 2) step(1'b1, 1'b0, 4'b0000, 1'b1, acc);
      chk("drain_msb", exp_m.size() == 0, 1'b1);
      chk("drain_lsb", exp_l.size() == 0, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_shift_register_piso_tx
`default_nettype wire

// File: doc/shift_register_piso_tx.md
Name: shift_register_piso_tx

Overview:
Parallel-in serial-out transmitter register. It accepts a WIDTH-bit word through a valid/ready load handshake and shifts it out one bit per clock with a bit-valid/bit-ready handshake. It sits at the sending end of our serial register links and feeds a serial-in parallel-out receiver. It supports back-to-back words with no idle gap.

Parameters:
WIDTH, 4, word width in bits (>=2)
LSB_FIRST, 0, 0 = MSB shifted out first; 1 = LSB shifted out first

Ports:
clk  input  1  clock; all state updates on posedge
clear_n  input  1  synchronous active-low reset, sampled on posedge clk
load_valid  input  1  parallel_in holds a word to send
parallel_in  input  WIDTH  word to serialize
load_ready  output  1  transmitter can accept a word this cycle
serial_out  output  1  current serial bit
serial_valid  output  1  serial_out is a valid data bit
serial_ready  input  1  downstream consumes serial_out this cycle
done  output  1  one-cycle pulse after the last bit of a word is consumed

Behaviour:
- Synchronous reset: clear_n=0 at a posedge forces state IDLE, shift register 0, bit counter 0, done 0.
  - Resulting outputs: serial_valid=0, serial_out=0, load_ready=1.
  - Reset overrides every other input, including mid-word. The partial word is abandoned and done is not pulsed.
- States: IDLE, SHIFT.
- serial_valid = (state==SHIFT).
- serial_out = shift register MSB (LSB_FIRST=0) or LSB (LSB_FIRST=1). It is driven from the register, not combinationally from parallel_in.
- load_ready = (state==IDLE) OR (state==SHIFT AND count==0 AND serial_ready).
  - This is combinational, so a new word can load on the same edge the last bit is consumed.
- Load: at a posedge with load_valid AND load_ready:
  - shift register <= parallel_in; count <= WIDTH-1; state <= SHIFT.
  - The first bit appears on serial_out in the following cycle (1-cycle latency).
- SHIFT, with serial_ready=1 at a posedge:
  - If count != 0: shift toward the output end, zero-fill, count <= count-1.
  - If count == 0: the word is complete. done <= 1. state <= SHIFT if a load occurs on the same edge, otherwise IDLE.
- SHIFT, with serial_ready=0: shift register, count, serial_out and serial_valid are all held.
- done is registered and high for exactly one cycle after each completed word.
  - When a second word loads back-to-back, done coincides with the new word's first bit.
- Without stalls a word occupies exactly WIDTH consecutive serial_valid cycles.
- load_valid while load_ready=0 is ignored; the word is not captured, and the source must hold it.
- parallel_in changes while the transmitter is busy have no effect on the word in flight.
- Counter width: clog2(WIDTH) bits. The counter never wraps below 0.

Decomposition:
- Shared package/include shift_reg_pkg holds:
  - state encoding localparams ST_IDLE=1'b0, ST_SHIFT=1'b1;
  - a clog2 constant function, reused by the matching receiver.
- No sub-module. The counter and shifter are small and stay inline. Serial port naming matches the receiver so the two instantiate back-to-back in loopback benches.

Test Plan:
1. clear_n=0 for 2 cycles, then 1 -> serial_valid=0, serial_out=0, done=0 throughout reset; load_ready=1 after release.
2. WIDTH=4, LSB_FIRST=0, load 4'b1101, serial_ready=1 -> serial_out 1,1,0,1 on the 4 cycles after the load edge, serial_valid high exactly 4 cycles, done high on cycle 5 only.
3. Load 4'b1011; drop serial_ready for 3 cycles while bit 2 (0) is presented; pulse load_valid with 4'b0000 during the stall -> bit 2 held 4 cycles, full sequence 1,0,1,1, stray load ignored (load_ready=0), single done pulse.
4. Back-to-back: load 4'b1010, keep load_valid=1 with 4'b0110 ready when the last bit goes out -> 8 contiguous serial_valid cycles 1,0,1,0,0,1,1,0; done pulses at cycle 5 (with 2nd word's first bit) and cycle 9.
5. Load 4'b0101, assert clear_n=0 after 2 bits consumed -> next cycle serial_valid=0, serial_out=0, no done pulse, load_ready=1.
6. LSB_FIRST=1, load 4'b1101 -> serial_out 1,0,1,1, then done pulse.
